// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: hardwired Mini SRC control sequencer for fetch, br, jr, jal, nop and halt.
// Inputs : clk, clr (async active-high reset), IR_Data (opcode in [31:27]), CON_out, Stop.
// Outputs: fetch strobes (PC_out, MAR_in, IncPC, Read, MDR_in, MDR_out, IR_in),
//          execute strobes (Gra, Grb, Rout, Rin, CON_in, Y_in, C_out, Z_in, Zlow_out, PC_in, Link_in),
//          alu_instruction_bits, Run, illegal_op, br_taken_count.
// Optional: define BR_STATS_EN to count taken branches in br_taken_count.
module branch_seq_ctrl #(
    parameter int         MEM_WAIT = 1,
    parameter logic [4:0] OP_BR    = 5'b10011,
    parameter logic [4:0] OP_JR    = 5'b10100,
    parameter logic [4:0] OP_JAL   = 5'b10101,
    parameter logic [4:0] OP_NOP   = 5'b11010,
    parameter logic [4:0] OP_HALT  = 5'b11011,
    parameter logic [4:0] ALU_ADD  = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    input  logic        Stop,
    output logic        PC_out,
    output logic        MAR_in,
    output logic        IncPC,
    output logic        Read,
    output logic        MDR_in,
    output logic        MDR_out,
    output logic        IR_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Rout,
    output logic        Rin,
    output logic        CON_in,
    output logic        Y_in,
    output logic        C_out,
    output logic        Z_in,
    output logic        Zlow_out,
    output logic        PC_in,
    output logic        Link_in,
    output logic [4:0]  alu_instruction_bits,
    output logic        Run,
    output logic        illegal_op,
    output logic [15:0] br_taken_count
);
    typedef enum logic [3:0] {T0, T1, T2, DEC, BR1, BR2, BR3, BR4, JR1, JAL1, JAL2, HALT} state_t;
    state_t state, next;
    logic [3:0] wait_cnt;
    logic stop_req;
    logic [4:0] op;
    logic legal;
    state_t ret;
    logic unused_ir;
    assign op = IR_Data[31:27];
    assign unused_ir = ^IR_Data[26:0];
    assign legal = op inside {OP_BR, OP_JR, OP_JAL, OP_NOP, OP_HALT};
    // Every instruction end is a return point; a latched stop turns it into HALT.
    assign ret = stop_req ? HALT : T0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= T0;
        else     state <= next;
    end

    // Wait counter is loaded in T0 so T1 lasts exactly MEM_WAIT cycles.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_cnt <= '0;
            stop_req <= 1'b0;
        end else begin
            stop_req <= stop_req | Stop;
            wait_cnt <= (state == T0) ? 4'(MEM_WAIT - 1) :
                        (state == T1 && wait_cnt != 4'd0) ? wait_cnt - 4'd1 : wait_cnt;
        end
    end

    always_comb begin
        next = state;
        case (state)
            T0:   next = T1;
            T1:   next = (wait_cnt == 4'd0) ? T2 : T1;
            T2:   next = DEC;
            DEC:  next = (op == OP_BR)   ? BR1  :
                         (op == OP_JR)   ? JR1  :
                         (op == OP_JAL)  ? JAL1 :
                         (op == OP_HALT) ? HALT : ret;
            BR1:  next = BR2;
            BR2:  next = BR3;
            BR3:  next = BR4;
            BR4:  next = ret;
            JR1:  next = ret;
            JAL1: next = JAL2;
            JAL2: next = ret;
            HALT: next = HALT;
            default: next = T0;
        endcase
    end

    // Moore decode, forced low while clr is held so the datapath sees no strobes during reset.
    always_comb begin
        {PC_out, MAR_in, IncPC, Read, MDR_in, MDR_out, IR_in} = '0;
        {Gra, Grb, Rout, Rin, CON_in, Y_in, C_out, Z_in, Zlow_out, PC_in, Link_in} = '0;
        alu_instruction_bits = '0;
        Run = 1'b0;
        illegal_op = 1'b0;
        if (!clr) begin
            Run = (state != HALT);
            case (state)
                T0:   {PC_out, MAR_in, IncPC} = 3'b111;
                T1:   {Read, MDR_in} = 2'b11;
                T2:   {MDR_out, IR_in} = 2'b11;
                DEC:  illegal_op = !legal;
                BR1:  {Gra, Rout, CON_in} = 3'b111;
                BR2:  {PC_out, Y_in} = 2'b11;
                BR3:  begin
                    {C_out, Z_in} = 2'b11;
                    alu_instruction_bits = ALU_ADD;
                end
                BR4:  {Zlow_out, PC_in} = {1'b1, CON_out};
                JR1:  {Gra, Rout, PC_in} = 3'b111;
                JAL1: {PC_out, Link_in} = 2'b11;
                JAL2: {Gra, Rout, PC_in} = 3'b111;
                default: ;
            endcase
        end
    end

`ifdef BR_STATS_EN
    logic [15:0] taken_cnt;
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                          taken_cnt <= '0;
        else if (state == BR4 && CON_out) taken_cnt <= taken_cnt + 16'd1;
    end
    assign br_taken_count = taken_cnt;
`else
    assign br_taken_count = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb_branch_seq_ctrl: randomized self-checking bench for branch_seq_ctrl against a micro-step list model.
module tb_branch_seq_ctrl;
    typedef struct packed {
        logic pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in;
        logic gra, grb, rout, rin, con_in, y_in, c_out, z_in, zlow_out, pc_in, link_in;
        logic run, illegal;
        logic [4:0] alu;
    } ob_t;

    logic clk = 0, clr = 1, con = 0, stop = 0;
    logic [31:0] ir = '0;
    ob_t o1, o3;
    logic [15:0] cnt1, cnt3;
    int vectors = 0, miscompares = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    branch_seq_ctrl #(.MEM_WAIT(1)) dut (
        .clk(clk), .clr(clr), .IR_Data(ir), .CON_out(con), .Stop(stop),
        .PC_out(o1.pc_out), .MAR_in(o1.mar_in), .IncPC(o1.inc_pc), .Read(o1.read),
        .MDR_in(o1.mdr_in), .MDR_out(o1.mdr_out), .IR_in(o1.ir_in),
        .Gra(o1.gra), .Grb(o1.grb), .Rout(o1.rout), .Rin(o1.rin), .CON_in(o1.con_in),
        .Y_in(o1.y_in), .C_out(o1.c_out), .Z_in(o1.z_in), .Zlow_out(o1.zlow_out),
        .PC_in(o1.pc_in), .Link_in(o1.link_in), .alu_instruction_bits(o1.alu),
        .Run(o1.run), .illegal_op(o1.illegal), .br_taken_count(cnt1));

    branch_seq_ctrl #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .clr(clr), .IR_Data(ir), .CON_out(con), .Stop(stop),
        .PC_out(o3.pc_out), .MAR_in(o3.mar_in), .IncPC(o3.inc_pc), .Read(o3.read),
        .MDR_in(o3.mdr_in), .MDR_out(o3.mdr_out), .IR_in(o3.ir_in),
        .Gra(o3.gra), .Grb(o3.grb), .Rout(o3.rout), .Rin(o3.rin), .CON_in(o3.con_in),
        .Y_in(o3.y_in), .C_out(o3.c_out), .Z_in(o3.z_in), .Zlow_out(o3.zlow_out),
        .PC_in(o3.pc_in), .Link_in(o3.link_in), .alu_instruction_bits(o3.alu),
        .Run(o3.run), .illegal_op(o3.illegal), .br_taken_count(cnt3));

    // Expected outputs of one named micro-step, taken straight from the step table.
    function automatic ob_t step(string n, bit c, bit ill);
        ob_t s = '0;
        s.run = 1;
        case (n)
            "T0":   begin s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; end
            "T1":   begin s.read = 1; s.mdr_in = 1; end
            "T2":   begin s.mdr_out = 1; s.ir_in = 1; end
            "DEC":  s.illegal = ill;
            "BR1":  begin s.gra = 1; s.rout = 1; s.con_in = 1; end
            "BR2":  begin s.pc_out = 1; s.y_in = 1; end
            "BR3":  begin s.c_out = 1; s.z_in = 1; s.alu = 5'b00011; end
            "BR4":  begin s.zlow_out = 1; s.pc_in = c; end
            "JAL1": begin s.pc_out = 1; s.link_in = 1; end
            "JR":   begin s.gra = 1; s.rout = 1; s.pc_in = 1; end
            default: ;
        endcase
        return s;
    endfunction

    task automatic check_cnt(string name);
        logic [15:0] want;
`ifdef BR_STATS_EN
        want = 16'(exp_cnt);
`else
        want = 16'h0000;
`endif
        vectors++;
        if (cnt1 !== want) begin
            miscompares++;
            $display("FAIL %s br_taken_count got %h want %h", name, cnt1, want);
        end
    endtask

    task automatic check_idle(string name);
        vectors++;
        if (o1 !== ob_t'(0) || o3 !== ob_t'(0)) begin
            miscompares++;
            $display("FAIL %s outputs got %h / %h want 0", name, o1, o3);
        end
    endtask

    // Runs one instruction from its T0 (entered and left on a negedge); stop_at pulses Stop at that step.
    task automatic exec(input logic [31:0] instr, input bit c, input int stop_at, input bit use3, string name);
        ob_t q[$];
        ob_t got;
        logic [4:0] op;
        bit legal, halts;
        op = instr[31:27];
        legal = op inside {5'b10011, 5'b10100, 5'b10101, 5'b11010, 5'b11011};
        q.push_back(step("T0", 0, 0));
        repeat (use3 ? 3 : 1) q.push_back(step("T1", 0, 0));
        q.push_back(step("T2", 0, 0));
        q.push_back(step("DEC", 0, !legal));
        if (op == 5'b10011) begin
            q.push_back(step("BR1", 0, 0)); q.push_back(step("BR2", 0, 0));
            q.push_back(step("BR3", 0, 0)); q.push_back(step("BR4", c, 0));
            if (c && !use3) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        end else if (op == 5'b10100) q.push_back(step("JR", 0, 0));
        else if (op == 5'b10101) begin
            q.push_back(step("JAL1", 0, 0)); q.push_back(step("JR", 0, 0));
        end
        halts = (op == 5'b11011) || (stop_at >= 0);
        ir = instr;
        con = c;
        foreach (q[i]) begin
            stop = (i == stop_at);
            #1;
            got = use3 ? o3 : o1;
            vectors++;
            if (got !== q[i]) begin
                miscompares++;
                $display("FAIL %s step %0d outputs got %h want %h", name, i, got, q[i]);
            end
            vectors++;
            if ($countones({got.pc_out, got.rout, got.mdr_out, got.zlow_out, got.c_out}) > 1) begin
                miscompares++;
                $display("FAIL %s step %0d bus drivers got %h want at most one", name, i, got);
            end
            @(negedge clk);
        end
        stop = 0;
        if (!use3) check_cnt(name);
        if (halts) repeat (3) begin
            #1;
            got = use3 ? o3 : o1;
            vectors++;
            if (got !== ob_t'(0)) begin
                miscompares++;
                $display("FAIL %s halt outputs got %h want 0", name, got);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        clr = 1;
        stop = 0;
        @(negedge clk);
        clr = 0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr = 0;
        ir = 32'h99000023;
        con = 1;
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (o1 !== step("BR2", 0, 0)) begin
            miscompares++;
            $display("FAIL reset_pre BR2 got %h want %h", o1, step("BR2", 0, 0));
        end
        clr = 1;
        #1 check_idle("reset_hold0");
        @(negedge clk);
        #1 check_idle("reset_hold1");
        @(negedge clk);
        clr = 0;
        exp_cnt = 0;
        #1;
        vectors++;
        if (o1 !== step("T0", 0, 0)) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", o1, step("T0", 0, 0));
        end
        check_cnt("reset_cnt");
    endtask

    task automatic test_branch();
        exec(32'h99000023, 1, -1, 0, "br_taken");
        exec(32'h99000023, 0, -1, 0, "br_not_taken");
        exec(32'h99000023, 1, -1, 0, "br_taken2");
    endtask

    task automatic test_jal_jr();
        exec(32'hAB000000, 0, -1, 0, "jal");
        exec(32'hA3800000, 1, -1, 0, "jr");
    endtask

    task automatic test_mem_wait();
        do_reset();
        exec(32'hD0000000, 0, -1, 1, "nop_wait3_a");
        exec(32'hD0000000, 0, -1, 1, "nop_wait3_b");
        exec(32'h99000023, 1, -1, 1, "br_wait3");
        do_reset();
    endtask

    task automatic test_random();
        logic [4:0] op;
        logic [4:0] legal_ops [4] = '{5'b10011, 5'b10100, 5'b10101, 5'b11010};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 5'($urandom); while (op inside {5'b10011, 5'b10100, 5'b10101, 5'b11010, 5'b11011});
            end else op = legal_ops[$urandom_range(0, 3)];
            exec({op, 27'($urandom)}, 1'($urandom), -1, 0, "random");
        end
    endtask

    task automatic test_illegal();
        exec(32'hF8000000, 1, -1, 0, "illegal");
        exec(32'hD0000000, 0, -1, 0, "after_illegal");
    endtask

    task automatic test_stop();
        exec(32'h99000023, 1, 5, 0, "stop_in_br2");
        do_reset();
        exec(32'hD0000000, 0, 2, 0, "stop_in_nop");
        do_reset();
        exec(32'hD8000000, 0, -1, 0, "halt_op");
        do_reset();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jal_jr();
        test_illegal();
        test_random();
        test_mem_wait();
        test_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
- Hardwired control sequencer for the Mini SRC datapath, covering instruction fetch, the control-transfer class (br, jr, jal), plus nop and halt.
- Reads IR_Data and CON_out from the datapath and drives its bus select/enable strobes, one micro-step per clock.
- Standalone first slice of the full control unit; the ALU/memory instruction classes are added to the same FSM later.

Parameters:
- MEM_WAIT, 1, cycles Read/MDR_in are held in fetch step T1 (1..15).
- OP_BR, 5'b10011, br opcode (IR[31:27]).
- OP_JR, 5'b10100, jr opcode.
- OP_JAL, 5'b10101, jal opcode.
- OP_NOP, 5'b11010, nop opcode.
- OP_HALT, 5'b11011, halt opcode.
- ALU_ADD, 5'b00011, alu_instruction_bits code for add.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- IR_Data  in  32  instruction register contents.
- CON_out  in  1  branch-condition flip-flop output.
- Stop  in  1  finish the current instruction, then halt.
- PC_out, MAR_in, IncPC, Read, MDR_in, MDR_out, IR_in  out  1 each  fetch strobes.
- Gra, Grb, Rout, Rin, CON_in, Y_in, C_out, Z_in, Zlow_out, PC_in, Link_in  out  1 each  execute strobes. Link_in writes R15.
- alu_instruction_bits  out  5  ALU op select.
- Run  out  1  high while sequencing.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- br_taken_count  out  16  taken-branch statistic.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While clr=1:
  - state = T0, wait counter = 0.
  - All outputs = 0, including Run and alu_instruction_bits.
- After clr falls, Run=1 and T0 outputs assert in the same cycle.
- Outputs are Moore decodes of the state. The one exception is PC_in in BR4, which is gated by CON_out.
- Each strobe is sampled by the datapath at the rising edge that ends its state.
- alu_instruction_bits = ALU_ADD in BR3; 0 in every other state.
- Fetch:
  - T0: PC_out, MAR_in, IncPC.
  - T1: Read, MDR_in, held MEM_WAIT cycles via a 4-bit down-counter; advance when the counter reaches 0.
  - T2: MDR_out, IR_in.
  - DEC: no strobes; branch on IR_Data[31:27].
- DEC transitions:
  - OP_BR -> BR1; OP_JR -> JR1; OP_JAL -> JAL1.
  - OP_NOP -> T0 (or HALT if the stop request is latched).
  - OP_HALT -> HALT.
  - Any other opcode: illegal_op=1 for the DEC cycle, then -> T0 (treated as nop).
- br:
  - BR1: Gra, Rout, CON_in.
  - BR2: PC_out, Y_in.
  - BR3: C_out, Z_in, alu=ALU_ADD.
  - BR4: Zlow_out, PC_in = CON_out.
  - -> T0.
  - Taken brzr with MEM_WAIT=1 is 8 cycles total (T0..BR4).
- jr: JR1: Gra, Rout, PC_in -> T0.
- jal:
  - JAL1: PC_out, Link_in.
  - JAL2: Gra, Rout, PC_in -> T0.
  - jal r15 therefore jumps to the old PC+1.
- Stop:
  - Sampled every cycle into a sticky stop_req flag.
  - At any return-to-T0 point with stop_req=1, go to HALT instead.
  - Stop never aborts mid-instruction.
- HALT: Run=0, all strobes 0, stays there until clr.
- clr asserted mid-instruction: immediate return to T0 with all outputs 0; stop_req is cleared.
- At most one of PC_out, Rout, MDR_out, Zlow_out, C_out is 1 in any state (single bus driver).

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - br_taken_count increments by 1 in every BR4 cycle with CON_out=1.
  - Cleared by clr; wraps 0xFFFF -> 0x0000.
- Undefined: br_taken_count tied to 16'h0000 and no counter logic is instantiated.

Test Plan:
- Reset: clr=1 for 2 cycles mid-BR2 -> all outputs 0 and Run=0 during clr; first cycle after release shows PC_out=MAR_in=IncPC=1.
- brzr taken: IR=0x99000023 (br, Ra=R2, C2=0), CON_out=1 in BR4 -> strobe sequence T0,T1,T2,DEC,BR1..BR4 over 8 cycles; PC_in=1 in BR4; alu=5'b00011 only in BR3; br_taken_count=1 with BR_STATS_EN.
- brzr not taken: same IR, CON_out=0 -> PC_in=0 in BR4, next cycle is T0; br_taken_count unchanged.
- jal then jr: IR=0xAB000000 gives JAL1 {PC_out, Link_in}, then JAL2 {Gra, Rout, PC_in}; IR=0xA3800000 gives a single JR1 {Gra, Rout, PC_in}.
- MEM_WAIT=3 with IR=nop: Read=MDR_in=1 for exactly 3 cycles; T0 recurs every 6 cycles.
- Stop pulsed for 1 cycle during BR2 -> br completes through BR4, then HALT with Run=0; IR=0xF8000000 (opcode 11111) gives a one-cycle illegal_op pulse, then T0.
